backend_stage_chain: RTL and testbench
======================================

BACKEND_STAGE_CHAIN -- requirements
Module: backend_stage_chain

Interface
REQ-001 SHALL have parameter STAGES, default 4, number of pipeline stages; stage 0 is youngest, STAGES-1 is writeback; legal range 2..8.
REQ-002 SHALL have parameter DATA_W, default 32, result width.
REQ-003 SHALL have parameter CTRL_W, default 16, opaque per-instruction control width.
REQ-004 SHALL have parameter NUM_RD, default 2, number of forwarding read ports.
REQ-005 SHALL have ports:
 clk  in  1  single clock; one clock, all state on rising edge.
 rst  in  1  reset, synchronous, active-high.
 issue_i  in  1  new instruction presented to stage 0.
 ctrl_i  in  CTRL_W  control word of the issued instruction.
 waddr_i  in  5  destination register; 0 = no write.
 data_i  in  DATA_W  initial result.
 rdy_i  in  1  data_i is final.
 stall_i  in  STAGES-1  per-stage hold request, stages 0..STAGES-2.
 clr_i  in  STAGES-1  per-stage squash, stages 0..STAGES-2.
 upd_valid_i  in  STAGES  per-stage late-result write strobe.
 upd_data_i  in  STAGES*DATA_W  per-stage late-result data.
 rd_addr_i  in  NUM_RD*5  forwarding lookup addresses.
 rf_data_i  in  NUM_RD*DATA_W  register-file data per port.
 fwd_data_o  out  NUM_RD*DATA_W  forwarded operand per port.
 fwd_wait_o  out  NUM_RD  producer found but result not ready.
 valid_o  out  STAGES  per-stage valid.
 ctrl_o  out  STAGES*CTRL_W  per-stage control word.
 wb_valid_o  out  1  stage STAGES-1 holds a valid writing instruction.
 wb_waddr_o  out  5  writeback address.
 wb_data_o  out  DATA_W  writeback data.

Function
REQ-006 SHALL keep per stage k: valid, ctrl, waddr, result, rdy.
REQ-007 SHALL compute effective hold hold[k] = OR of stall_i[k..STAGES-2]; stage STAGES-1 never holds.
REQ-008 Stage 0, not held: loads {1, ctrl_i, waddr_i, data_i, rdy_i} when issue_i, else a bubble (valid 0, ctrl 0, waddr 0). Held: keeps contents; issue_i ignored.
REQ-009 Stage k>0, not held: loads stage k-1 contents if stage k-1 not held and clr_i[k-1]=0, else a bubble.
REQ-010 clr_i[k] on a held stage k SHALL make stage k a bubble next cycle.
REQ-011 upd_valid_i[k] SHALL write upd_data_i[k] into the instruction leaving or staying in stage k: the destination stage receives result=upd_data_i[k], rdy=1 at that edge; ignored when stage k invalid or clr_i[k]=1.
REQ-012 Forwarding per port p SHALL be combinational: scan stages 0..STAGES-1, select lowest k with valid, waddr!=0, waddr==rd_addr_i[p]; output that stage's registered result; fwd_wait_o[p]=~rdy of that stage.
REQ-013 No match, or rd_addr_i[p]==0: fwd_data_o[p]=rf_data_i[p] (0 when address 0), fwd_wait_o[p]=0.
REQ-014 wb_valid_o = valid[STAGES-1] and waddr!=0; wb_waddr_o, wb_data_o from stage STAGES-1; an unready result reaching writeback is written as held (no check).
REQ-015 Latency: issue at edge t, no holds, instruction in stage k after edge t+k, visible on wb outputs during cycle t+STAGES-1.
REQ-016 Simultaneous hold and clear on stage k: clear wins (bubble).
REQ-017 Upd on stage k same cycle as clr_i[k]: dropped.

Reset
REQ-018 rst=1 at an edge SHALL clear valid, ctrl, waddr, result, rdy of all stages; all outputs 0 except fwd_data_o=rf_data_i passthrough; reset overrides issue, stall, clear, upd in that cycle, including mid-flight instructions.

Verification
REQ-019 Issue waddr=3,data=0xA5,rdy=1 at t, no stalls, STAGES=4 -> wb_valid_o=1, wb_data_o=0xA5 in cycle t+3 only.
REQ-020 Stage 1 and 2 both hold waddr=5 (data 0x11, 0x22), rd_addr=5 -> fwd_data_o=0x11; rd_addr=0 -> 0, wait 0.
REQ-021 Issue rdy=0 waddr=7, lookup 7 -> fwd_wait_o=1; upd_valid_i[2]=1 data 0x99 -> after that edge wait 0, data 0x99.
REQ-022 stall_i[1]=1 for 2 cycles with instrs in stages 0,1,2 -> stages 0,1 frozen, stage 2 advances, stage 2 bubble next; release -> order preserved.
REQ-023 clr_i[0]=1 with stage 0 valid, no hold -> stage 1 bubble next cycle; with stall_i[0]=1 -> stage 0 invalid next cycle.
REQ-024 rst mid-flight with 3 valid stages -> all valid_o 0 next cycle, no wb_valid_o pulse.

Source files
------------

// File: rtl/backend_stage_chain.sv
// In-order backend pipeline with per-stage hold/squash, late result updates,
// operand forwarding with youngest-producer priority, and a writeback port.
module backend_stage_chain #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_i,
    input  logic [CTRL_W-1:0]          ctrl_i,
    input  logic [4:0]                 waddr_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       rdy_i,
    input  logic [STAGES-2:0]          stall_i,
    input  logic [STAGES-2:0]          clr_i,
    input  logic [STAGES-1:0]          upd_valid_i,
    input  logic [STAGES*DATA_W-1:0]   upd_data_i,
    input  logic [NUM_RD*5-1:0]        rd_addr_i,
    input  logic [NUM_RD*DATA_W-1:0]   rf_data_i,
    output logic [NUM_RD*DATA_W-1:0]   fwd_data_o,
    output logic [NUM_RD-1:0]          fwd_wait_o,
    output logic [STAGES-1:0]          valid_o,
    output logic [STAGES*CTRL_W-1:0]   ctrl_o,
    output logic                       wb_valid_o,
    output logic [4:0]                 wb_waddr_o,
    output logic [DATA_W-1:0]          wb_data_o
);
    localparam int NS = int'(STAGES);
    localparam int NR = int'(NUM_RD);
    localparam int DW = int'(DATA_W);

    logic [STAGES-1:0]              valid_q, valid_d, rdy_q, rdy_d;
    logic [STAGES-1:0][CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [STAGES-1:0][4:0]         waddr_q, waddr_d;
    logic [STAGES-1:0][DATA_W-1:0]  result_q, result_d, res_eff;
    logic [STAGES-1:0]              rdy_eff, upd_ok, hold, clr_ext;
    logic [NUM_RD-1:0]              fwd_hit;

    // The writeback stage has no squash input.
    assign clr_ext = {1'b0, clr_i};

    // A stall anywhere downstream also freezes every older-facing stage behind it.
    always_comb begin
        hold = '0;
        for (int k = 0; k < NS - 1; k++) begin
            for (int j = k; j < NS - 1; j++) begin
                hold[k] = hold[k] | stall_i[j];
            end
        end
    end

    // Late results follow the instruction to wherever it lands this edge.
    always_comb begin
        for (int k = 0; k < NS; k++) begin
            upd_ok[k]  = upd_valid_i[k] & valid_q[k] & ~clr_ext[k];
            res_eff[k] = upd_ok[k] ? upd_data_i[k*DW +: DW] : result_q[k];
            rdy_eff[k] = upd_ok[k] | rdy_q[k];
        end
    end

    always_comb begin
        valid_d  = '0;
        ctrl_d   = '0;
        waddr_d  = '0;
        result_d = '0;
        rdy_d    = '0;
        if (hold[0]) begin
            if (!clr_ext[0]) begin
                valid_d[0]  = valid_q[0];
                ctrl_d[0]   = ctrl_q[0];
                waddr_d[0]  = waddr_q[0];
                result_d[0] = res_eff[0];
                rdy_d[0]    = rdy_eff[0];
            end
        end else if (issue_i) begin
            valid_d[0]  = 1'b1;
            ctrl_d[0]   = ctrl_i;
            waddr_d[0]  = waddr_i;
            result_d[0] = data_i;
            rdy_d[0]    = rdy_i;
        end
        for (int k = 1; k < NS; k++) begin
            if (hold[k]) begin
                if (!clr_ext[k]) begin
                    valid_d[k]  = valid_q[k];
                    ctrl_d[k]   = ctrl_q[k];
                    waddr_d[k]  = waddr_q[k];
                    result_d[k] = res_eff[k];
                    rdy_d[k]    = rdy_eff[k];
                end
            end else if (!hold[k-1] && !clr_ext[k-1]) begin
                valid_d[k]  = valid_q[k-1];
                ctrl_d[k]   = ctrl_q[k-1];
                waddr_d[k]  = waddr_q[k-1];
                result_d[k] = res_eff[k-1];
                rdy_d[k]    = rdy_eff[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            ctrl_q   <= '0;
            waddr_q  <= '0;
            result_q <= '0;
            rdy_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            waddr_q  <= waddr_d;
            result_q <= result_d;
            rdy_q    <= rdy_d;
        end
    end

    // Youngest matching producer wins; address 0 never forwards.
    always_comb begin
        fwd_data_o = '0;
        fwd_wait_o = '0;
        fwd_hit    = '0;
        for (int p = 0; p < NR; p++) begin
            if (rd_addr_i[p*5 +: 5] != 5'd0) begin
                fwd_data_o[p*DW +: DW] = rf_data_i[p*DW +: DW];
                for (int k = 0; k < NS; k++) begin
                    if (!fwd_hit[p] && valid_q[k] && waddr_q[k] == rd_addr_i[p*5 +: 5]) begin
                        fwd_hit[p]             = 1'b1;
                        fwd_data_o[p*DW +: DW] = result_q[k];
                        fwd_wait_o[p]          = ~rdy_q[k];
                    end
                end
            end
        end
    end

    assign valid_o    = valid_q;
    assign ctrl_o     = ctrl_q;
    assign wb_valid_o = valid_q[NS-1] && (waddr_q[NS-1] != 5'd0);
    assign wb_waddr_o = waddr_q[NS-1];
    assign wb_data_o  = result_q[NS-1];

endmodule

// File: tb/tb_backend_stage_chain.sv
// Bench for backend_stage_chain: latency table, directed hold/clear/forward
// sequences, then random traffic against an instruction-level model.
module tb_backend_stage_chain;
    localparam int S  = 4;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_i;
    logic [CW-1:0]     ctrl_i;
    logic [4:0]        waddr_i;
    logic [DW-1:0]     data_i;
    logic              rdy_i;
    logic [S-2:0]      stall_i;
    logic [S-2:0]      clr_i;
    logic [S-1:0]      upd_valid_i;
    logic [S*DW-1:0]   upd_data_i;
    logic [NR*5-1:0]   rd_addr_i;
    logic [NR*DW-1:0]  rf_data_i;
    logic [NR*DW-1:0]  fwd_data_o;
    logic [NR-1:0]     fwd_wait_o;
    logic [S-1:0]      valid_o;
    logic [S*CW-1:0]   ctrl_o;
    logic              wb_valid_o;
    logic [4:0]        wb_waddr_o;
    logic [DW-1:0]     wb_data_o;

    backend_stage_chain #(
        .STAGES(S), .DATA_W(DW), .CTRL_W(CW), .NUM_RD(NR)
    ) dut (
        .clk(clk), .rst(rst), .issue_i(issue_i), .ctrl_i(ctrl_i), .waddr_i(waddr_i),
        .data_i(data_i), .rdy_i(rdy_i), .stall_i(stall_i), .clr_i(clr_i),
        .upd_valid_i(upd_valid_i), .upd_data_i(upd_data_i), .rd_addr_i(rd_addr_i),
        .rf_data_i(rf_data_i), .fwd_data_o(fwd_data_o), .fwd_wait_o(fwd_wait_o),
        .valid_o(valid_o), .ctrl_o(ctrl_o), .wb_valid_o(wb_valid_o),
        .wb_waddr_o(wb_waddr_o), .wb_data_o(wb_data_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction-level reference: each occupied slot is squashed, stays, or moves on.
    typedef struct {
        bit            v;
        logic [CW-1:0] c;
        logic [4:0]    a;
        logic [DW-1:0] r;
        bit            y;
    } ins_t;

    ins_t pipe[S];

    function automatic ins_t bubble();
        ins_t b;
        b.v = 1'b0; b.c = '0; b.a = '0; b.r = '0; b.y = 1'b0;
        return b;
    endfunction

    function automatic bit held(int k);
        bit h = 1'b0;
        for (int j = k; j < S - 1; j++) h = h | stall_i[j];
        return h;
    endfunction

    function automatic bit clr_at(int k);
        return (k < S - 1) ? clr_i[k] : 1'b0;
    endfunction

    function automatic void model_step();
        ins_t nxt[S];
        for (int k = 0; k < S; k++) nxt[k] = bubble();
        if (!rst) begin
            for (int k = S - 1; k >= 0; k--) begin
                ins_t x;
                x = pipe[k];
                if (x.v && !clr_at(k)) begin
                    if (upd_valid_i[k]) begin
                        x.r = upd_data_i[k*DW +: DW];
                        x.y = 1'b1;
                    end
                    if (held(k)) nxt[k] = x;
                    else if (k < S - 1) nxt[k+1] = x;
                end
            end
            if (!held(0) && issue_i) nxt[0] = '{1'b1, ctrl_i, waddr_i, data_i, rdy_i};
        end
        for (int k = 0; k < S; k++) pipe[k] = nxt[k];
    endfunction

    always @(posedge clk) model_step();

    task automatic compare_model();
        logic [S-1:0]    ev;
        logic [S*CW-1:0] ec;
        for (int k = 0; k < S; k++) begin
            ev[k]          = pipe[k].v;
            ec[k*CW +: CW] = pipe[k].c;
        end
        chk("rnd valid_o", valid_o, ev);
        chk("rnd ctrl_o", ctrl_o, ec);
        chk("rnd wb_valid_o", wb_valid_o, pipe[S-1].v && pipe[S-1].a != 5'd0);
        if (pipe[S-1].v) begin
            chk("rnd wb_waddr_o", wb_waddr_o, pipe[S-1].a);
            chk("rnd wb_data_o", wb_data_o, pipe[S-1].r);
        end
        for (int p = 0; p < NR; p++) begin
            logic [4:0]    ad;
            logic [DW-1:0] ed;
            logic          ew;
            ad = rd_addr_i[p*5 +: 5];
            ed = (ad == 5'd0) ? '0 : rf_data_i[p*DW +: DW];
            ew = 1'b0;
            for (int k = S - 1; k >= 0; k--) begin
                if (ad != 5'd0 && pipe[k].v && pipe[k].a == ad) begin
                    ed = pipe[k].r;
                    ew = !pipe[k].y;
                end
            end
            chk("rnd fwd_data_o", fwd_data_o[p*DW +: DW], ed);
            chk("rnd fwd_wait_o", fwd_wait_o[p], ew);
        end
    endtask

    task automatic idle();
        issue_i = 1'b0; ctrl_i = '0; waddr_i = '0; data_i = '0; rdy_i = 1'b0;
        stall_i = '0; clr_i = '0; upd_valid_i = '0; upd_data_i = '0;
        rd_addr_i = '0; rf_data_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] a, input logic [DW-1:0] d, input logic y);
        issue_i = 1'b1; waddr_i = a; data_i = d; rdy_i = y; ctrl_i = d[CW-1:0];
    endtask

    typedef struct {
        bit         iss;
        logic [4:0] wa;
        logic [DW-1:0] d;
        bit         exp_v;
        logic [4:0] exp_a;
        logic [DW-1:0] exp_d;
    } vec_t;

    vec_t vt[9];

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rd_addr_i = {5'd4, 5'd2};
        rf_data_i = {32'h2222_0000, 32'h1111_0000};
        #1;
        chk("reset valid_o", valid_o, '0);
        chk("reset ctrl_o", ctrl_o, '0);
        chk("reset wb_valid_o", wb_valid_o, 1'b0);
        chk("reset wb_waddr_o", wb_waddr_o, 5'd0);
        chk("reset wb_data_o", wb_data_o, '0);
        chk("reset fwd_data_o", fwd_data_o, {32'h2222_0000, 32'h1111_0000});
        chk("reset fwd_wait_o", fwd_wait_o, '0);

        // Writeback latency: appears exactly STAGES-1 edges after the issuing edge.
        vt[0] = '{1'b1, 5'd3, 32'hA5,   1'b0, 5'd0, 32'h0};
        vt[1] = '{1'b1, 5'd0, 32'h77,   1'b0, 5'd0, 32'h0};
        vt[2] = '{1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 32'h0};
        vt[3] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0};
        vt[4] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'hA5};
        vt[5] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0};
        vt[6] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'h1234};
        vt[7] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0};
        vt[8] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            idle();
            if (vt[c].iss) issue(vt[c].wa, vt[c].d, 1'b1);
            #1;
            chk($sformatf("tbl[%0d] wb_valid_o", c), wb_valid_o, vt[c].exp_v);
            if (vt[c].exp_v) begin
                chk($sformatf("tbl[%0d] wb_waddr_o", c), wb_waddr_o, vt[c].exp_a);
                chk($sformatf("tbl[%0d] wb_data_o", c), wb_data_o, vt[c].exp_d);
            end
            tick();
        end

        // Two producers of r5 in stages 1 and 2: the younger one forwards.
        do_reset();
        issue(5'd5, 32'h22, 1'b1); tick();
        issue(5'd5, 32'h11, 1'b1); tick();
        idle(); tick();
        rd_addr_i = {5'd0, 5'd5};
        rf_data_i = {32'hBBBB, 32'hAAAA};
        #1;
        chk("fwd2 valid_o", valid_o, 4'b0110);
        chk("fwd2 fwd_data_o", fwd_data_o, {32'h0, 32'h11});
        chk("fwd2 fwd_wait_o", fwd_wait_o, 2'b00);
        rd_addr_i = {5'd5, 5'd6};
        #1;
        chk("fwd miss fwd_data_o", fwd_data_o, {32'h11, 32'hAAAA});

        // Unready producer, then late update in stage 2.
        do_reset();
        issue(5'd7, 32'h1, 1'b0); tick();
        idle();
        rd_addr_i = {5'd0, 5'd7};
        #1;
        chk("wait fwd_wait_o", fwd_wait_o, 2'b01);
        chk("wait fwd_data_o", fwd_data_o[DW-1:0], 32'h1);
        tick(); tick();
        upd_valid_i = 4'b0100;
        upd_data_i[2*DW +: DW] = 32'h99;
        #1;
        chk("upd pre fwd_wait_o", fwd_wait_o, 2'b01);
        tick();
        upd_valid_i = '0;
        #1;
        chk("upd fwd_wait_o", fwd_wait_o, 2'b00);
        chk("upd fwd_data_o", fwd_data_o[DW-1:0], 32'h99);
        chk("upd wb_valid_o", wb_valid_o, 1'b1);
        chk("upd wb_data_o", wb_data_o, 32'h99);

        // Stall stage 1 for two cycles with A,B,C in stages 2,1,0.
        do_reset();
        issue(5'd1, 32'hA, 1'b1); tick();
        issue(5'd2, 32'hB, 1'b1); tick();
        issue(5'd3, 32'hC, 1'b1); tick();
        issue(5'd4, 32'hD, 1'b1);
        stall_i = 3'b010;
        tick();
        chk("stall1 valid_o", valid_o, 4'b1011);
        chk("stall1 ctrl_o", ctrl_o, {16'hA, 16'h0, 16'hB, 16'hC});
        chk("stall1 wb_waddr_o", wb_waddr_o, 5'd1);
        tick();
        chk("stall2 valid_o", valid_o, 4'b0011);
        chk("stall2 ctrl_o", ctrl_o, {16'h0, 16'h0, 16'hB, 16'hC});
        idle(); tick();
        chk("release valid_o", valid_o, 4'b0110);
        chk("release ctrl_o", ctrl_o, {16'h0, 16'hB, 16'hC, 16'h0});
        tick();
        chk("order1 wb_waddr_o", wb_waddr_o, 5'd2);
        chk("order1 wb_data_o", wb_data_o, 32'hB);
        tick();
        chk("order2 wb_waddr_o", wb_waddr_o, 5'd3);
        chk("order2 wb_data_o", wb_data_o, 32'hC);

        // Squash of stage 0, first while flowing, then while held.
        do_reset();
        issue(5'd6, 32'hE, 1'b1); tick();
        idle(); clr_i = 3'b001; tick();
        idle();
        chk("clr flow valid_o", valid_o, 4'b0000);
        issue(5'd6, 32'hF, 1'b1); tick();
        idle(); stall_i = 3'b001; clr_i = 3'b001; tick();
        idle();
        chk("clr held valid_o", valid_o, 4'b0000);

        // Reset with three instructions in flight.
        do_reset();
        issue(5'd1, 32'h1, 1'b1); tick();
        issue(5'd2, 32'h2, 1'b1); tick();
        issue(5'd3, 32'h3, 1'b1); tick();
        chk("pre-rst valid_o", valid_o, 4'b0111);
        rst = 1'b1;
        issue(5'd4, 32'h4, 1'b1);
        tick();
        rst = 1'b0;
        idle();
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("rst[%0d] valid_o", c), valid_o, 4'b0000);
            chk($sformatf("rst[%0d] wb_valid_o", c), wb_valid_o, 1'b0);
            tick();
        end

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 99) == 0);
            issue_i     = ($urandom_range(0, 9) < 7);
            ctrl_i      = CW'($urandom);
            waddr_i     = 5'($urandom_range(0, 7));
            data_i      = $urandom;
            rdy_i       = $urandom_range(0, 1) == 1;
            for (int k = 0; k < S - 1; k++) begin
                stall_i[k] = ($urandom_range(0, 5) == 0);
                clr_i[k]   = ($urandom_range(0, 7) == 0);
            end
            for (int k = 0; k < S; k++) begin
                upd_valid_i[k]         = ($urandom_range(0, 2) == 0);
                upd_data_i[k*DW +: DW] = $urandom;
            end
            for (int p = 0; p < NR; p++) begin
                rd_addr_i[p*5 +: 5]    = 5'($urandom_range(0, 7));
                rf_data_i[p*DW +: DW]  = $urandom;
            end
            #1;
            compare_model();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
